equ_serpar_buffer: RTL and testbench
====================================

EQU_SERPAR_BUFFER -- requirements
Module: equ_serpar_buffer

Interface
REQ-001 Parameter DATA_W, default 16, signed width of each I/Q component of one equalized subcarrier.
REQ-002 Parameter N_SC, default 12, subcarriers per SC-FDMA symbol.
REQ-003 i_clk_equ  input  1  equalizer clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_rst_ser_par  input  1  active-low clear of the fill bank, from equalizer FSM.
REQ-006 i_wr_en  input  1  equalized sample valid this cycle.
REQ-007 i_wr_add  input  4  subcarrier index of sample.
REQ-008 i_data_re, i_data_im  input  DATA_W each  signed equalized sample.
REQ-009 i_done_equ  input  1  single-cycle pulse: current symbol fully written.
REQ-010 i_sym_ready  input  1  downstream (demapper) accepts symbol.
REQ-011 o_sym_re, o_sym_im  output  N_SC*DATA_W each  parallel symbol, lane k at bits [k*DATA_W +: DATA_W].
REQ-012 o_sym_valid  output  1  parallel symbol available.
REQ-013 o_err_addr, o_err_incomplete, o_err_overflow  output  1 each  single-cycle error pulses.

Function
REQ-014 Two banks (ping-pong), each N_SC complex registers plus N_SC-bit written-mask; pointers wr_bank, rd_bank; flags full[1:0].
REQ-015 i_wr_en=1, i_wr_add<N_SC, fill bank not full: sample stored in lane i_wr_add of wr_bank, mask bit set, next edge.
REQ-016 i_wr_en=1 with i_wr_add>=N_SC: write discarded, o_err_addr=1 next cycle.
REQ-017 i_rst_ser_par=0: wr_bank mask cleared; a write in the same cycle is applied after the clear (lane stored, its mask bit set).
REQ-018 Clear never affects a full bank or its data.
REQ-019 i_done_equ=1 with mask all-ones: full[wr_bank] set, wr_bank toggles, next edge; o_sym_valid high from following cycle (latency 1).
REQ-020 i_done_equ=1 with mask incomplete: bank not committed, mask cleared, o_err_incomplete=1 next cycle.
REQ-021 Both banks full: any write or i_done_equ dropped, o_err_overflow=1 next cycle; stored data unchanged.
REQ-022 o_sym_valid = full[rd_bank]; o_sym_re/im driven from rd_bank lanes, stable while o_sym_valid=1 and i_sym_ready=0.
REQ-023 Handshake: o_sym_valid & i_sym_ready at edge clears full[rd_bank], toggles rd_bank.
REQ-024 Simultaneous commit (REQ-019) and handshake (REQ-023): both applied same edge; no symbol lost or duplicated.
REQ-025 Duplicate write to a lane before commit overwrites data; no error.
REQ-026 Per-bank view as state machine: EMPTY (mask 0) -> FILLING (first write) -> FULL (commit) -> EMPTY (handshake); FILLING -> EMPTY on clear or incomplete done.

Reset
REQ-027 i_rst=1 at edge: both masks, full[1:0], wr_bank, rd_bank, all error pulses = 0; o_sym_valid=0.
REQ-028 Lane data registers need not be reset; o_sym_re/im are don't-care while o_sym_valid=0.
REQ-029 Reset mid-fill or with a symbol pending discards all symbols; first post-reset output requires a fresh full symbol.

Structure
REQ-030 Shared package equ_pkg holds N_SC, DATA_W default, subcarrier-index type and bank-state enum (EMPTY, FILLING, FULL).
REQ-031 One sub-module equ_sc_bank (N_SC-lane register file + written-mask), instantiated twice.

Verification
REQ-032 Clear, write lanes 0..11 with re=k, im=-k, pulse done, ready=1 -> o_sym_valid one cycle after done, lane k = (k,-k), valid drops after one cycle.
REQ-033 Two symbols back-to-back, ready=0 -> both banks full, third done gives o_err_overflow=1; ready then releases symbol 1 then symbol 2 in order.
REQ-034 Write lanes 0..10 only, pulse done -> o_err_incomplete=1, o_sym_valid stays 0.
REQ-035 Write with i_wr_add=12 and 15 -> o_err_addr=1 each, no mask or data change.
REQ-036 Commit symbol B in same cycle symbol A is accepted -> B presented next cycle, o_sym_valid continuously 1.
REQ-037 i_rst=1 while one bank full and other filling -> next cycle o_sym_valid=0, all flags 0.

Source files
------------

// File: rtl/equ_pkg.sv
// Shared constants and types for the equalizer serial-to-parallel symbol buffer.
package equ_pkg;
  localparam int N_SC   = 12;
  localparam int DATA_W = 16;

  typedef logic [3:0] sc_idx_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  function automatic logic lane_ok(input sc_idx_t idx, input int n_sc);
    return int'(idx) < n_sc;
  endfunction
endpackage

// File: rtl/equ_serpar_buffer_if.sv
// Equalizer-side write bus and demapper-side parallel symbol handshake.
interface equ_serpar_buffer_if
  #(parameter int DATA_W = equ_pkg::DATA_W,
    parameter int N_SC   = equ_pkg::N_SC);
  import equ_pkg::*;

  logic                     i_rst_ser_par;
  logic                     i_wr_en;
  sc_idx_t                  i_wr_add;
  logic signed [DATA_W-1:0] i_data_re;
  logic signed [DATA_W-1:0] i_data_im;
  logic                     i_done_equ;
  logic                     i_sym_ready;
  logic [N_SC*DATA_W-1:0]   o_sym_re;
  logic [N_SC*DATA_W-1:0]   o_sym_im;
  logic                     o_sym_valid;
  logic                     o_err_addr;
  logic                     o_err_incomplete;
  logic                     o_err_overflow;

  modport master (
    output i_rst_ser_par, i_wr_en, i_wr_add, i_data_re, i_data_im, i_done_equ, i_sym_ready,
    input  o_sym_re, o_sym_im, o_sym_valid, o_err_addr, o_err_incomplete, o_err_overflow
  );

  modport slave (
    input  i_rst_ser_par, i_wr_en, i_wr_add, i_data_re, i_data_im, i_done_equ, i_sym_ready,
    output o_sym_re, o_sym_im, o_sym_valid, o_err_addr, o_err_incomplete, o_err_overflow
  );
endinterface

// File: rtl/equ_sc_bank.sv
// One ping-pong bank: N_SC complex lane registers, a written-mask and the
// EMPTY -> FILLING -> FULL -> EMPTY bank state.
module equ_sc_bank
  #(parameter int DATA_W = equ_pkg::DATA_W,
    parameter int N_SC   = equ_pkg::N_SC)
  (
    input  logic                     i_clk_equ,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  equ_pkg::sc_idx_t         i_wr_lane,
    input  logic signed [DATA_W-1:0] i_wr_re,
    input  logic signed [DATA_W-1:0] i_wr_im,
    input  logic                     i_commit,
    input  logic                     i_drop,
    input  logic                     i_release,
    output logic                     o_full,
    output logic                     o_complete,
    output logic [N_SC*DATA_W-1:0]   o_lanes_re,
    output logic [N_SC*DATA_W-1:0]   o_lanes_im
  );
  import equ_pkg::*;

  bank_state_t              r_state, w_state_next;
  logic [N_SC-1:0]          r_mask, w_mask_next, w_lane_bit;
  logic signed [DATA_W-1:0] r_re [N_SC];
  logic signed [DATA_W-1:0] r_im [N_SC];
  logic                     w_wr_ok;

  assign w_wr_ok    = i_wr & (r_state != FULL);
  assign w_lane_bit = w_wr_ok ? ((N_SC)'(1) << i_wr_lane) : '0;

  always_ff @(posedge i_clk_equ) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
    end
  end

  // A clear or rejected done wipes the mask first; a same-cycle write then re-marks its lane.
  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    case (r_state)
      FULL: begin
        if (i_release) w_state_next = EMPTY;
      end
      default: begin
        if (i_commit) begin
          w_state_next = FULL;
          w_mask_next  = '0;
        end else begin
          if (i_clr || i_drop) w_mask_next = '0;
          w_mask_next  = w_mask_next | w_lane_bit;
          w_state_next = (w_mask_next == '0) ? EMPTY : FILLING;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk_equ) begin
    if (w_wr_ok) begin
      r_re[i_wr_lane] <= i_wr_re;
      r_im[i_wr_lane] <= i_wr_im;
    end
  end

  assign o_full     = (r_state == FULL);
  assign o_complete = &r_mask;

  generate
    for (genvar gi = 0; gi < N_SC; gi++) begin : g_lane
      assign o_lanes_re[gi*DATA_W +: DATA_W] = r_re[gi];
      assign o_lanes_im[gi*DATA_W +: DATA_W] = r_im[gi];
    end
  endgenerate
endmodule

// File: rtl/equ_serpar_buffer.sv
// Collects serially equalized subcarriers into ping-pong banks and presents
// each completed SC-FDMA symbol in parallel to the demapper.
module equ_serpar_buffer
  #(parameter int DATA_W = equ_pkg::DATA_W,
    parameter int N_SC   = equ_pkg::N_SC)
  (
    input  logic               i_clk_equ,
    input  logic               i_rst,
    equ_serpar_buffer_if.slave bus
  );
  import equ_pkg::*;

  logic                   r_wr_bank, r_rd_bank;
  logic                   r_err_addr, r_err_incomplete, r_err_overflow;
  logic [1:0]             w_full, w_complete;
  logic [N_SC*DATA_W-1:0] w_lanes_re [2];
  logic [N_SC*DATA_W-1:0] w_lanes_im [2];
  logic                   w_fill_full, w_addr_ok, w_wr, w_commit, w_drop, w_hs;

  // The fill bank can only be full when both banks hold pending symbols.
  assign w_fill_full = w_full[r_wr_bank];
  assign w_addr_ok   = lane_ok(bus.i_wr_add, N_SC);
  assign w_wr        = bus.i_wr_en & w_addr_ok & ~w_fill_full;
  assign w_commit    = bus.i_done_equ & ~w_fill_full & w_complete[r_wr_bank];
  assign w_drop      = bus.i_done_equ & ~w_fill_full & ~w_complete[r_wr_bank];
  assign w_hs        = w_full[r_rd_bank] & bus.i_sym_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      logic w_sel_wr, w_sel_rd;
      assign w_sel_wr = (r_wr_bank == BANK_ID);
      assign w_sel_rd = (r_rd_bank == BANK_ID);

      equ_sc_bank #(.DATA_W(DATA_W), .N_SC(N_SC)) u_bank (
        .i_clk_equ  (i_clk_equ),
        .i_rst      (i_rst),
        .i_clr      (~bus.i_rst_ser_par & w_sel_wr),
        .i_wr       (w_wr & w_sel_wr),
        .i_wr_lane  (bus.i_wr_add),
        .i_wr_re    (bus.i_data_re),
        .i_wr_im    (bus.i_data_im),
        .i_commit   (w_commit & w_sel_wr),
        .i_drop     (w_drop & w_sel_wr),
        .i_release  (w_hs & w_sel_rd),
        .o_full     (w_full[gi]),
        .o_complete (w_complete[gi]),
        .o_lanes_re (w_lanes_re[gi]),
        .o_lanes_im (w_lanes_im[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk_equ) begin
    if (i_rst) begin
      r_wr_bank        <= 1'b0;
      r_rd_bank        <= 1'b0;
      r_err_addr       <= 1'b0;
      r_err_incomplete <= 1'b0;
      r_err_overflow   <= 1'b0;
    end else begin
      if (w_commit) r_wr_bank <= ~r_wr_bank;
      if (w_hs)     r_rd_bank <= ~r_rd_bank;
      r_err_addr       <= bus.i_wr_en & ~w_addr_ok;
      r_err_incomplete <= w_drop;
      r_err_overflow   <= w_fill_full & (bus.i_wr_en | bus.i_done_equ);
    end
  end

  assign bus.o_sym_valid      = w_full[r_rd_bank];
  assign bus.o_sym_re         = w_lanes_re[r_rd_bank];
  assign bus.o_sym_im         = w_lanes_im[r_rd_bank];
  assign bus.o_err_addr       = r_err_addr;
  assign bus.o_err_incomplete = r_err_incomplete;
  assign bus.o_err_overflow   = r_err_overflow;
endmodule

// File: tb/tb_equ_serpar_buffer.sv
// Bench for equ_serpar_buffer: directed scenarios plus randomized symbol traffic,
// checked every cycle against a queue-based model of pending symbols.
module tb_equ_serpar_buffer;
  import equ_pkg::*;

  localparam int W  = DATA_W;
  localparam int N  = N_SC;
  localparam int VW = N * W;
  typedef logic [VW-1:0] vec_t;

  logic i_clk_equ = 1'b0;
  logic i_rst     = 1'b1;

  equ_serpar_buffer_if #(.DATA_W(W), .N_SC(N)) bus ();

  equ_serpar_buffer #(.DATA_W(W), .N_SC(N)) dut (
    .i_clk_equ (i_clk_equ),
    .i_rst     (i_rst),
    .bus       (bus)
  );

  always #5 i_clk_equ = ~i_clk_equ;

  // Model: FIFO of pending symbols (at most two) plus the symbol being filled.
  vec_t                q_re[$], q_im[$];
  logic signed [W-1:0] f_re [N];
  logic signed [W-1:0] f_im [N];
  bit                  written [N];
  bit                  e_addr, e_inc, e_ovf;
  int                  n_cmp = 0, n_bad = 0, n_sym = 0;

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_written();
    for (int k = 0; k < N; k++) written[k] = 1'b0;
  endtask

  task automatic tick();
    bit   full2, hs, all_w, commit;
    vec_t v_re, v_im;
    @(posedge i_clk_equ);
    if (i_rst) begin
      q_re.delete();
      q_im.delete();
      clear_written();
      e_addr = 1'b0;
      e_inc  = 1'b0;
      e_ovf  = 1'b0;
    end else begin
      full2 = (q_re.size() == 2);
      hs    = (q_re.size() > 0) && bus.i_sym_ready;
      all_w = 1'b1;
      for (int k = 0; k < N; k++) if (!written[k]) all_w = 1'b0;
      commit = bus.i_done_equ && !full2 && all_w;
      e_addr = bus.i_wr_en && (int'(bus.i_wr_add) >= N);
      e_ovf  = full2 && (bus.i_wr_en || bus.i_done_equ);
      e_inc  = bus.i_done_equ && !full2 && !all_w;
      if (!full2 && (!bus.i_rst_ser_par || e_inc)) clear_written();
      if (!full2 && bus.i_wr_en && (int'(bus.i_wr_add) < N)) begin
        f_re[int'(bus.i_wr_add)]    = bus.i_data_re;
        f_im[int'(bus.i_wr_add)]    = bus.i_data_im;
        written[int'(bus.i_wr_add)] = 1'b1;
      end
      if (hs) begin
        $display("[%0t] symbol %0d delivered re=%h", $time, n_sym, q_re[0]);
        n_sym++;
        void'(q_re.pop_front());
        void'(q_im.pop_front());
      end
      if (commit) begin
        for (int k = 0; k < N; k++) begin
          v_re[k*W +: W] = f_re[k];
          v_im[k*W +: W] = f_im[k];
        end
        q_re.push_back(v_re);
        q_im.push_back(v_im);
        clear_written();
      end
    end
    #1;
    chk("sym_valid",      VW'(bus.o_sym_valid),      VW'(q_re.size() > 0));
    chk("err_addr",       VW'(bus.o_err_addr),       VW'(e_addr));
    chk("err_incomplete", VW'(bus.o_err_incomplete), VW'(e_inc));
    chk("err_overflow",   VW'(bus.o_err_overflow),   VW'(e_ovf));
    if (q_re.size() > 0) begin
      chk("sym_re", bus.o_sym_re, q_re[0]);
      chk("sym_im", bus.o_sym_im, q_im[0]);
    end
  endtask

  task automatic wr(input int lane, input int re, input int im);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_add  = 4'(lane);
    bus.i_data_re = W'(re);
    bus.i_data_im = W'(im);
    tick();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    bus.i_done_equ = 1'b1;
    tick();
    bus.i_done_equ = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.i_rst_ser_par = 1'b0;
    tick();
    bus.i_rst_ser_par = 1'b1;
  endtask

  task automatic fill(input int base, input int n_lanes);
    for (int k = 0; k < n_lanes; k++) wr(k, base + k, -(base + k));
  endtask

  task automatic rtick();
    bus.i_sym_ready = ($urandom_range(0, 2) != 0);
    tick();
  endtask

  initial begin
    bus.i_rst_ser_par = 1'b1;
    bus.i_wr_en       = 1'b0;
    bus.i_wr_add      = '0;
    bus.i_data_re     = '0;
    bus.i_data_im     = '0;
    bus.i_done_equ    = 1'b0;
    bus.i_sym_ready   = 1'b0;

    // Reset state
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    // Single symbol lane k = (k, -k), delivered immediately
    bus.i_sym_ready = 1'b1;
    pulse_clear();
    fill(0, N);
    pulse_done();
    tick();
    tick();

    // Two symbols held, third done overflows, then ordered release
    bus.i_sym_ready = 1'b0;
    fill(100, N);
    pulse_done();
    fill(200, N);
    pulse_done();
    wr(3, 7, 7);
    pulse_done();
    tick();
    bus.i_sym_ready = 1'b1;
    tick();
    tick();
    tick();

    // Incomplete symbol
    fill(300, N - 1);
    pulse_done();
    tick();

    // Out-of-range addresses, then a complete symbol proving the mask was untouched
    wr(12, 1, 1);
    wr(15, 2, 2);
    fill(400, N);
    wr(5, 55, -55);
    pulse_done();
    tick();

    // Commit B in the same cycle A is accepted
    bus.i_sym_ready = 1'b0;
    fill(500, N);
    pulse_done();
    fill(600, N);
    bus.i_sym_ready = 1'b1;
    pulse_done();
    tick();
    tick();

    // Reset with one bank full and one filling
    bus.i_sym_ready = 1'b0;
    fill(700, N);
    pulse_done();
    fill(800, 4);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    fill(900, N);
    pulse_done();
    bus.i_sym_ready = 1'b1;
    tick();
    tick();

    // Randomized symbol traffic
    for (int s = 0; s < 80; s++) begin
      int order [N];
      int tmp, j, skip;
      for (int k = 0; k < N; k++) order[k] = k;
      for (int k = N - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = order[k];
        order[k] = order[j];
        order[j] = tmp;
      end
      skip = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      if ($urandom_range(0, 3) == 0) begin
        bus.i_rst_ser_par = 1'b0;
        rtick();
        bus.i_rst_ser_par = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
        if (order[k] == skip) continue;
        bus.i_wr_en   = 1'b1;
        bus.i_wr_add  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(N, 15)) : 4'(order[k]);
        bus.i_data_re = W'($urandom);
        bus.i_data_im = W'($urandom);
        rtick();
        if ($urandom_range(0, 7) == 0) begin
          bus.i_data_re = W'($urandom);
          rtick();
        end
        bus.i_wr_en = 1'b0;
        if ($urandom_range(0, 3) == 0) rtick();
      end
      bus.i_done_equ = 1'b1;
      rtick();
      bus.i_done_equ = 1'b0;
    end

    bus.i_sym_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
